// File: rtl/id_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module  : id_scoreboard_pkg
// Purpose : Shared constants and helpers for the decode-stage register
//           scoreboard (register index width, register count, counter width).
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package id_scoreboard_pkg;

   localparam int                   REG_IDX_W       = 5;
   localparam int                   NUM_REGS        = 32;
   localparam logic [REG_IDX_W-1:0] REG_ZERO        = 5'd0;
   localparam int                   SB_CNT_W        = 2;
   localparam int                   SB_MAX_INFLIGHT = 3;

   // True when an enabled event targets register r; x0 never matches.
   function automatic logic idx_hit(input logic                 en,
                                    input logic [REG_IDX_W-1:0] idx,
                                    input logic [REG_IDX_W-1:0] r);
      return en && (idx == r) && (r != REG_ZERO);
   endfunction

endpackage
`default_nettype wire

// File: rtl/id_scoreboard_sb_counter.sv
`default_nettype none
// ============================================================================
// Module  : sb_counter
// Purpose : One saturating up/down pending-write counter of the scoreboard.
//           Net change per cycle is inc - dec_wb - dec_kill; results outside
//           [0, MAX_INFLIGHT] are clamped and flagged on o_err.
// Ports   : clk, rst        - clock, synchronous active-high reset
//           i_inc           - an issued instruction will write this register
//           i_dec_wb        - a write to this register retires this cycle
//           i_dec_kill      - a pending write to this register is squashed
//           o_cnt           - current count (registered)
//           o_cnt_nxt       - count that will be loaded on the next edge
//           o_err           - this cycle's update over/underflowed (comb)
// Revision: 1.0 - initial release
// ============================================================================
module sb_counter #(
   parameter int CNT_W        = 2,
   parameter int MAX_INFLIGHT = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_inc,
   input  logic             i_dec_wb,
   input  logic             i_dec_kill,
   output logic [CNT_W-1:0] o_cnt,
   output logic [CNT_W-1:0] o_cnt_nxt,
   output logic             o_err
);

   localparam logic signed [CNT_W+1:0] c_max = (CNT_W+2)'(MAX_INFLIGHT);

   logic        [CNT_W-1:0] r_cnt;
   logic signed [CNT_W:0]   w_delta;
   logic signed [CNT_W+1:0] w_sum;

   always_comb begin
      w_delta   = $signed({{CNT_W{1'b0}}, i_inc})
                - $signed({{CNT_W{1'b0}}, i_dec_wb})
                - $signed({{CNT_W{1'b0}}, i_dec_kill});
      // Zero-extend the count, sign-extend the delta: the sum spans
      // -2 .. MAX+1 and needs two extra bits.
      w_sum     = $signed({2'b00, r_cnt}) + $signed({w_delta[CNT_W], w_delta});
      o_err     = 1'b0;
      o_cnt_nxt = w_sum[CNT_W-1:0];
      if (w_sum > c_max) begin
         o_cnt_nxt = CNT_W'(MAX_INFLIGHT);
         o_err     = 1'b1;
      end else if (w_sum[CNT_W+1]) begin
         o_cnt_nxt = '0;
         o_err     = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= o_cnt_nxt;
      end
   end

   assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/id_scoreboard.sv
`default_nettype none
// ============================================================================
// Module  : id_scoreboard
// Purpose : Decode-stage register scoreboard and stall controller. Tracks the
//           number of in-flight writes per architectural register, stalls
//           decode on unresolved sources and counts stall cycles.
// Ports   : clk, rst                    - clock, synchronous active-high reset
//           id_valid                    - decode holds a valid instruction
//           rs1, rs2, rs1_used, rs2_used- source indices and read enables
//           id_regWrite, id_rd          - decoded instruction's destination
//           wb_regWrite, wb_rd          - writeback commit this cycle
//           kill_valid, kill_regWrite,
//           kill_rd                     - squash of the instruction in EX
//           stall                       - hold decode / bubble EX (comb)
//           issue                       - instruction advances (comb)
//           busy                        - any write pending (registered)
//           stall_cycles                - stall cycle counter (registered)
//           sb_error                    - sticky over/underflow (registered)
// Revision: 1.0 - initial release
// ============================================================================
module id_scoreboard
   import id_scoreboard_pkg::*;
#(
   parameter int MAX_INFLIGHT = SB_MAX_INFLIGHT,
   // Must satisfy 2**CNT_W - 1 >= MAX_INFLIGHT.
   parameter int CNT_W        = SB_CNT_W,
   parameter int WB_BYPASS    = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 id_valid,
   input  logic [REG_IDX_W-1:0] rs1,
   input  logic [REG_IDX_W-1:0] rs2,
   input  logic                 rs1_used,
   input  logic                 rs2_used,
   input  logic                 id_regWrite,
   input  logic [REG_IDX_W-1:0] id_rd,
   input  logic                 wb_regWrite,
   input  logic [REG_IDX_W-1:0] wb_rd,
   input  logic                 kill_valid,
   input  logic [REG_IDX_W-1:0] kill_rd,
   input  logic                 kill_regWrite,
   output logic                 stall,
   output logic                 issue,
   output logic                 busy,
   output logic [31:0]          stall_cycles,
   output logic                 sb_error
);

   logic [CNT_W-1:0]    w_cnt [NUM_REGS];
   logic [NUM_REGS-1:1] w_err;
   logic [NUM_REGS-1:1] w_nz_nxt;

   logic [CNT_W-1:0] w_cnt_rs1;
   logic [CNT_W-1:0] w_cnt_rs2;
   logic             w_rs1_pend;
   logic             w_rs2_pend;
   logic             w_rs1_byp;
   logic             w_rs2_byp;
   logic             w_stall;
   logic             w_issue;

   logic             r_busy;
   logic             r_sb_error;
   logic [31:0]      r_stall_cycles;

   // x0 is never tracked; its slot reads as zero so lookups need no guard.
   assign w_cnt[0] = '0;

   generate
      for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
         localparam logic [REG_IDX_W-1:0] c_r = REG_IDX_W'(r);

         logic             w_inc;
         logic             w_dec_wb;
         logic             w_dec_kill;
         logic [CNT_W-1:0] w_nxt;

         assign w_inc      = idx_hit(w_issue && id_regWrite, id_rd, c_r);
         assign w_dec_wb   = idx_hit(wb_regWrite, wb_rd, c_r);
         assign w_dec_kill = idx_hit(kill_valid && kill_regWrite, kill_rd, c_r);

         sb_counter #(
            .CNT_W        (CNT_W),
            .MAX_INFLIGHT (MAX_INFLIGHT)
         ) u_cnt (
            .clk        (clk),
            .rst        (rst),
            .i_inc      (w_inc),
            .i_dec_wb   (w_dec_wb),
            .i_dec_kill (w_dec_kill),
            .o_cnt      (w_cnt[r]),
            .o_cnt_nxt  (w_nxt),
            .o_err      (w_err[r])
         );

         assign w_nz_nxt[r] = |w_nxt;
      end
   endgenerate

   // Source lookup and stall terms. The bypass exception applies only when
   // the retiring write is the last one pending and nothing else this cycle
   // re-targets the register. The decode-side check uses id_valid rather
   // than issue so the stall path never depends on its own result; this is
   // conservative only for an instruction that both reads and writes x.
   always_comb begin
      w_cnt_rs1  = w_cnt[rs1];
      w_cnt_rs2  = w_cnt[rs2];

      w_rs1_pend = id_valid && rs1_used && (rs1 != REG_ZERO) && (w_cnt_rs1 != '0);
      w_rs2_pend = id_valid && rs2_used && (rs2 != REG_ZERO) && (w_cnt_rs2 != '0);

      w_rs1_byp  = (WB_BYPASS != 0) && (w_cnt_rs1 == CNT_W'(1))
                && wb_regWrite && (wb_rd == rs1)
                && !(kill_valid && kill_regWrite && (kill_rd == rs1))
                && !(id_valid && id_regWrite && (id_rd == rs1));
      w_rs2_byp  = (WB_BYPASS != 0) && (w_cnt_rs2 == CNT_W'(1))
                && wb_regWrite && (wb_rd == rs2)
                && !(kill_valid && kill_regWrite && (kill_rd == rs2))
                && !(id_valid && id_regWrite && (id_rd == rs2));

      w_stall    = (w_rs1_pend && !w_rs1_byp) || (w_rs2_pend && !w_rs2_byp);
      w_issue    = id_valid && !w_stall;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy         <= 1'b0;
         r_sb_error     <= 1'b0;
         r_stall_cycles <= 32'd0;
      end else begin
         // busy mirrors the counter values being loaded on this edge.
         r_busy     <= |w_nz_nxt;
         r_sb_error <= r_sb_error | (|w_err);
         if (w_stall) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
         end
      end
   end

   assign stall        = w_stall;
   assign issue        = w_issue;
   assign busy         = r_busy;
   assign sb_error     = r_sb_error;
   assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire
